// File: rtl/cpu_pkg.sv
// Shared encodings for the single-bus CPU control path: opcodes, ALU operation codes,
// sequencer step encoding and IR field positions.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_JR   = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_MFHI = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [5:0] ALU_NONE = 6'd0;
   localparam logic [5:0] ALU_ADD  = 6'd1;
   localparam logic [5:0] ALU_SUB  = 6'd2;
   localparam logic [5:0] ALU_AND  = 6'd3;
   localparam logic [5:0] ALU_OR   = 6'd4;
   localparam logic [5:0] ALU_SHR  = 6'd5;
   localparam logic [5:0] ALU_SHRA = 6'd6;
   localparam logic [5:0] ALU_SHL  = 6'd7;
   localparam logic [5:0] ALU_ROR  = 6'd8;
   localparam logic [5:0] ALU_ROL  = 6'd9;
   localparam logic [5:0] ALU_MUL  = 6'd10;
   localparam logic [5:0] ALU_DIV  = 6'd11;
   localparam logic [5:0] ALU_NEG  = 6'd12;
   localparam logic [5:0] ALU_NOT  = 6'd13;

   localparam logic [3:0] ST_RESET = 4'd0;
   localparam logic [3:0] ST_T0    = 4'd1;
   localparam logic [3:0] ST_T1    = 4'd2;
   localparam logic [3:0] ST_T2    = 4'd3;
   localparam logic [3:0] ST_T3    = 4'd4;
   localparam logic [3:0] ST_T4    = 4'd5;
   localparam logic [3:0] ST_T5    = 4'd6;
   localparam logic [3:0] ST_T6    = 4'd7;
   localparam logic [3:0] ST_T7    = 4'd8;
   localparam logic [3:0] ST_HALT  = 4'd9;

   localparam int unsigned OPC_LSB = 27;
   localparam int unsigned RA_LSB  = 23;
   localparam int unsigned RB_LSB  = 19;
   localparam int unsigned RC_LSB  = 15;

   // jal writes the return address here
   localparam logic [3:0] LINK_REG = 4'd15;

   function automatic logic [5:0] alu_of(input logic [4:0] opc);
      case (opc)
         OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: alu_of = ALU_ADD;
         OP_SUB:             alu_of = ALU_SUB;
         OP_AND, OP_ANDI:    alu_of = ALU_AND;
         OP_OR, OP_ORI:      alu_of = ALU_OR;
         OP_SHR:             alu_of = ALU_SHR;
         OP_SHRA:            alu_of = ALU_SHRA;
         OP_SHL:             alu_of = ALU_SHL;
         OP_ROR:             alu_of = ALU_ROR;
         OP_ROL:             alu_of = ALU_ROL;
         OP_MUL:             alu_of = ALU_MUL;
         OP_DIV:             alu_of = ALU_DIV;
         OP_NEG:             alu_of = ALU_NEG;
         OP_NOT:             alu_of = ALU_NOT;
         default:            alu_of = ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_encode.sv
// Turns the Gra/Grb/Grc field selects plus Rin/Rout/BAout into one-hot register
// load and bus-out vectors.
module reg_select_encode #(
   parameter int unsigned NREGS = 16
) (
   input  logic [3:0]       ra,
   input  logic [3:0]       rb,
   input  logic [3:0]       rc,
   input  logic             gra,
   input  logic             grb,
   input  logic             grc,
   input  logic             rin,
   input  logic             rout,
   input  logic             ba_out,
   output logic [NREGS-1:0] r_in,
   output logic [NREGS-1:0] r_out
);

   logic [3:0]       sel;
   logic [NREGS-1:0] sel_oh;

   always_comb begin
      sel = 4'd0;
      if (gra) sel = sel | ra;
      if (grb) sel = sel | rb;
      if (grc) sel = sel | rc;
   end

   // Indices beyond NREGS shift out to an empty vector rather than wrapping.
   assign sel_oh = NREGS'(1) << sel;
   assign r_in   = rin ? sel_oh : '0;
   assign r_out  = (rout || ba_out) ? sel_oh : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU: steps fetch T0-T2 and execute T3-T7,
// decoding every bus select, load enable, memory strobe and ALU op from step and IR.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned NREGS = 16,
   parameter int unsigned OP_W  = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [31:0]      ir,
   input  logic             con_ff,
   input  logic             mem_ready,
   input  logic             stop,
   output logic             pc_out,
   output logic             mdr_out,
   output logic             zhigh_out,
   output logic             zlow_out,
   output logic             hi_out,
   output logic             lo_out,
   output logic             c_out,
   output logic             inport_out,
   output logic [NREGS-1:0] r_out,
   output logic             ba_out,
   output logic [NREGS-1:0] r_in,
   output logic             mar_in,
   output logic             mdr_in,
   output logic             ir_in,
   output logic             pc_in,
   output logic             y_in,
   output logic             z_in,
   output logic             hi_in,
   output logic             lo_in,
   output logic             con_in,
   output logic             outport_in,
   output logic             inc_pc,
   output logic             read,
   output logic             write,
   output logic [OP_W-1:0]  alu_op,
   output logic             run
);

   logic [3:0]       state_q, state_d;
   logic             stop_seen_q, stop_seen_d;
   logic [4:0]       opc;
   logic             is_imm;
   logic             gra, grb, grc, rin, rout, link;
   logic             last, hold, halt_req;
   logic [5:0]       alu_sel;
   logic [NREGS-1:0] r_in_enc;
   logic             unused_ir_low;

   assign opc           = ir[OPC_LSB +: 5];
   assign is_imm        = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
   assign unused_ir_low = ^ir[14:0];

   reg_select_encode #(
      .NREGS (NREGS)
   ) u_reg_select (
      .ra     (ir[RA_LSB +: 4]),
      .rb     (ir[RB_LSB +: 4]),
      .rc     (ir[RC_LSB +: 4]),
      .gra    (gra),
      .grb    (grb),
      .grc    (grc),
      .rin    (rin),
      .rout   (rout),
      .ba_out (ba_out),
      .r_in   (r_in_enc),
      .r_out  (r_out)
   );

   assign r_in   = r_in_enc | (link ? (NREGS'(1) << LINK_REG) : '0);
   assign alu_op = OP_W'(alu_sel);
   assign run    = (state_q != ST_HALT) && (state_q != ST_RESET);

   // Outputs follow the step and IR; only the T1 exit pc_in and the taken-branch pc_in
   // are qualified by mem_ready / con_ff.
   always_comb begin
      pc_out = 1'b0; mdr_out = 1'b0; zhigh_out = 1'b0; zlow_out = 1'b0;
      hi_out = 1'b0; lo_out = 1'b0; c_out = 1'b0; inport_out = 1'b0; ba_out = 1'b0;
      mar_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0; pc_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
      hi_in = 1'b0; lo_in = 1'b0; con_in = 1'b0; outport_in = 1'b0; inc_pc = 1'b0;
      read = 1'b0; write = 1'b0; alu_sel = ALU_NONE;
      gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; link = 1'b0;
      last = 1'b0; hold = 1'b0;
      case (state_q)
         ST_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
         ST_T1: begin
            zlow_out = 1'b1; read = 1'b1; mdr_in = 1'b1;
            pc_in = mem_ready; hold = !mem_ready;
         end
         ST_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
         ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
            case (opc)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
               OP_ADDI, OP_ANDI, OP_ORI: begin
                  case (state_q)
                     ST_T3: begin grb = 1'b1; rout = 1'b1; y_in = 1'b1; end
                     ST_T4: begin
                        if (is_imm) c_out = 1'b1;
                        else begin grc = 1'b1; rout = 1'b1; end
                        alu_sel = alu_of(opc); z_in = 1'b1;
                     end
                     ST_T5: begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_NEG, OP_NOT: begin
                  case (state_q)
                     ST_T3: begin
                        grb = 1'b1; rout = 1'b1; alu_sel = alu_of(opc); z_in = 1'b1;
                     end
                     ST_T4: begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_MUL, OP_DIV: begin
                  case (state_q)
                     ST_T3: begin gra = 1'b1; rout = 1'b1; y_in = 1'b1; end
                     ST_T4: begin
                        grb = 1'b1; rout = 1'b1; alu_sel = alu_of(opc); z_in = 1'b1;
                     end
                     ST_T5: begin zlow_out = 1'b1; lo_in = 1'b1; end
                     ST_T6: begin zhigh_out = 1'b1; hi_in = 1'b1; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_LD, OP_LDI, OP_ST: begin
                  case (state_q)
                     ST_T3: begin grb = 1'b1; rout = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                     ST_T4: begin c_out = 1'b1; alu_sel = ALU_ADD; z_in = 1'b1; end
                     ST_T5: begin
                        zlow_out = 1'b1;
                        if (opc == OP_LDI) begin gra = 1'b1; rin = 1'b1; last = 1'b1; end
                        else mar_in = 1'b1;
                     end
                     ST_T6: begin
                        if (opc == OP_LD) begin
                           read = 1'b1; mdr_in = 1'b1; hold = !mem_ready;
                        end else if (opc == OP_ST) begin
                           gra = 1'b1; rout = 1'b1; mdr_in = 1'b1;
                        end else last = 1'b1;
                     end
                     default: begin
                        if (opc == OP_LD) begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
                        else if (opc == OP_ST) begin write = 1'b1; hold = !mem_ready; end
                        last = 1'b1;
                     end
                  endcase
               end
               OP_BR: begin
                  case (state_q)
                     ST_T3: begin gra = 1'b1; rout = 1'b1; con_in = 1'b1; end
                     ST_T4: begin pc_out = 1'b1; y_in = 1'b1; end
                     ST_T5: begin c_out = 1'b1; alu_sel = ALU_ADD; z_in = 1'b1; end
                     ST_T6: begin zlow_out = 1'b1; pc_in = con_ff; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_JR: begin gra = 1'b1; rout = 1'b1; pc_in = 1'b1; last = 1'b1; end
               OP_JAL: begin
                  if (state_q == ST_T3) begin pc_out = 1'b1; link = 1'b1; end
                  else begin gra = 1'b1; rout = 1'b1; pc_in = 1'b1; last = 1'b1; end
               end
               OP_IN:   begin inport_out = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
               OP_OUT:  begin gra = 1'b1; rout = 1'b1; outport_in = 1'b1; last = 1'b1; end
               OP_MFHI: begin hi_out = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
               OP_MFLO: begin lo_out = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
               default: last = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   assign halt_req = stop_seen_q || stop || (opc == OP_HALT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_T0;
         ST_HALT:  state_d = ST_HALT;
         default: begin
            if (!hold) begin
               if (last) state_d = halt_req ? ST_HALT : ST_T0;
               else      state_d = state_q + 4'd1;
            end
         end
      endcase
   end

   // The stop request is collected afresh from T0 of every instruction.
   always_comb begin
      case (state_q)
         ST_RESET, ST_HALT: stop_seen_d = 1'b0;
         ST_T0:             stop_seen_d = stop;
         default:           stop_seen_d = stop_seen_q || stop;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= ST_RESET;
         stop_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stop_seen_q <= stop_seen_d;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction step lists feed an expected
// queue that a negedge monitor compares against the full control word every cycle.
module tb_control_sequencer;
   import cpu_pkg::*;

   typedef struct packed {
      logic        pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out, inport_out;
      logic [15:0] r_out;
      logic        ba_out;
      logic [15:0] r_in;
      logic        mar_in, mdr_in, ir_in, pc_in, y_in, z_in, hi_in, lo_in, con_in;
      logic        outport_in, inc_pc, read, write;
      logic [5:0]  alu_op;
      logic        run;
   } cw_t;

   typedef struct { cw_t cw; bit mem; } step_t;
   typedef struct { cw_t cw; string tag; } exp_t;

   logic        clk = 1'b0;
   logic        clr, con_ff, mem_ready, stop;
   logic [31:0] ir;
   logic        pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out, inport_out;
   logic [15:0] r_out, r_in;
   logic        ba_out, mar_in, mdr_in, ir_in, pc_in, y_in, z_in, hi_in, lo_in, con_in;
   logic        outport_in, inc_pc, read, write, run;
   logic [5:0]  alu_op;

   control_sequencer #(.NREGS(16), .OP_W(6)) dut (
      .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
      .pc_out(pc_out), .mdr_out(mdr_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
      .hi_out(hi_out), .lo_out(lo_out), .c_out(c_out), .inport_out(inport_out),
      .r_out(r_out), .ba_out(ba_out), .r_in(r_in), .mar_in(mar_in), .mdr_in(mdr_in),
      .ir_in(ir_in), .pc_in(pc_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
      .con_in(con_in), .outport_in(outport_in), .inc_pc(inc_pc), .read(read), .write(write),
      .alu_op(alu_op), .run(run)
   );

   always #5 clk = ~clk;

   exp_t  exp_q[$];
   step_t steps[$];
   int    checks = 0;
   int    errors = 0;
   string cur_tag = "reset";

   function automatic cw_t zero();
      cw_t w;
      w = '0;
      return w;
   endfunction

   function automatic cw_t busy();
      cw_t w;
      w = '0;
      w.run = 1'b1;
      return w;
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] n);
      return 16'd1 << n;
   endfunction

   function automatic step_t mk(input cw_t w, input bit m);
      step_t s;
      s.cw = w;
      s.mem = m;
      return s;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 15'd0};
   endfunction

   function automatic logic [5:0] exp_alu(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         OP_SHR:          return ALU_SHR;
         OP_SHRA:         return ALU_SHRA;
         OP_SHL:          return ALU_SHL;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         default:         return ALU_NONE;
      endcase
   endfunction

   function automatic cw_t dut_word();
      cw_t a;
      a.pc_out = pc_out; a.mdr_out = mdr_out; a.zhigh_out = zhigh_out; a.zlow_out = zlow_out;
      a.hi_out = hi_out; a.lo_out = lo_out; a.c_out = c_out; a.inport_out = inport_out;
      a.r_out = r_out; a.ba_out = ba_out; a.r_in = r_in; a.mar_in = mar_in;
      a.mdr_in = mdr_in; a.ir_in = ir_in; a.pc_in = pc_in; a.y_in = y_in; a.z_in = z_in;
      a.hi_in = hi_in; a.lo_in = lo_in; a.con_in = con_in; a.outport_in = outport_in;
      a.inc_pc = inc_pc; a.read = read; a.write = write; a.alu_op = alu_op; a.run = run;
      return a;
   endfunction

   // Execute-phase step list for one instruction, straight from the instruction table.
   task automatic plan_exec(input logic [31:0] iv, input logic cf);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      cw_t w;
      op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
      steps.delete();
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
         OP_ADDI, OP_ANDI, OP_ORI: begin
            w = busy(); w.r_out = oh(rb); w.y_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.alu_op = exp_alu(op); w.z_in = 1;
            if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) w.c_out = 1;
            else w.r_out = oh(rc);
            steps.push_back(mk(w, 0));
            w = busy(); w.zlow_out = 1; w.r_in = oh(ra); steps.push_back(mk(w, 0));
         end
         OP_NEG, OP_NOT: begin
            w = busy(); w.r_out = oh(rb); w.alu_op = exp_alu(op); w.z_in = 1;
            steps.push_back(mk(w, 0));
            w = busy(); w.zlow_out = 1; w.r_in = oh(ra); steps.push_back(mk(w, 0));
         end
         OP_MUL, OP_DIV: begin
            w = busy(); w.r_out = oh(ra); w.y_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.r_out = oh(rb); w.alu_op = exp_alu(op); w.z_in = 1;
            steps.push_back(mk(w, 0));
            w = busy(); w.zlow_out = 1; w.lo_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.zhigh_out = 1; w.hi_in = 1; steps.push_back(mk(w, 0));
         end
         OP_LD, OP_LDI, OP_ST: begin
            w = busy(); w.r_out = oh(rb); w.ba_out = 1; w.y_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.c_out = 1; w.alu_op = ALU_ADD; w.z_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.zlow_out = 1;
            if (op == OP_LDI) w.r_in = oh(ra); else w.mar_in = 1;
            steps.push_back(mk(w, 0));
            if (op == OP_LD) begin
               w = busy(); w.read = 1; w.mdr_in = 1; steps.push_back(mk(w, 1));
               w = busy(); w.mdr_out = 1; w.r_in = oh(ra); steps.push_back(mk(w, 0));
            end else if (op == OP_ST) begin
               w = busy(); w.r_out = oh(ra); w.mdr_in = 1; steps.push_back(mk(w, 0));
               w = busy(); w.write = 1; steps.push_back(mk(w, 1));
            end
         end
         OP_BR: begin
            w = busy(); w.r_out = oh(ra); w.con_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.pc_out = 1; w.y_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.c_out = 1; w.alu_op = ALU_ADD; w.z_in = 1; steps.push_back(mk(w, 0));
            w = busy(); w.zlow_out = 1; w.pc_in = cf; steps.push_back(mk(w, 0));
         end
         OP_JR: begin
            w = busy(); w.r_out = oh(ra); w.pc_in = 1; steps.push_back(mk(w, 0));
         end
         OP_JAL: begin
            w = busy(); w.pc_out = 1; w.r_in = 16'h8000; steps.push_back(mk(w, 0));
            w = busy(); w.r_out = oh(ra); w.pc_in = 1; steps.push_back(mk(w, 0));
         end
         OP_IN: begin
            w = busy(); w.inport_out = 1; w.r_in = oh(ra); steps.push_back(mk(w, 0));
         end
         OP_OUT: begin
            w = busy(); w.r_out = oh(ra); w.outport_in = 1; steps.push_back(mk(w, 0));
         end
         OP_MFHI: begin
            w = busy(); w.hi_out = 1; w.r_in = oh(ra); steps.push_back(mk(w, 0));
         end
         OP_MFLO: begin
            w = busy(); w.lo_out = 1; w.r_in = oh(ra); steps.push_back(mk(w, 0));
         end
         default: steps.push_back(mk(busy(), 0));
      endcase
   endtask

   // Called at posedge+1: drives this cycle's inputs and queues the word expected now.
   task automatic do_cycle(input cw_t e, input logic c, input logic mr, input logic cf,
                           input logic st);
      exp_t x;
      clr = c; mem_ready = mr; con_ff = cf; stop = st;
      x.cw = e;
      x.tag = cur_tag;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input cw_t w, input logic mr);
      do_cycle(w, 1'b1, mr, 1'b0, 1'b0);
      do_cycle(zero(), 1'b1, 1'b1, 1'b0, 1'b0);
      do_cycle(zero(), 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_instr(input logic [31:0] iv, input logic cf, input int fdly,
                            input int mdly, input int stop_at, input int abort_at,
                            input string tag);
      step_t all[$];
      cw_t   w;
      int    idx;
      bit    seen;
      idx = 0;
      seen = 0;
      cur_tag = tag;
      w = busy(); w.pc_out = 1; w.mar_in = 1; w.inc_pc = 1; w.z_in = 1;
      all.push_back(mk(w, 0));
      w = busy(); w.zlow_out = 1; w.read = 1; w.mdr_in = 1; w.pc_in = 1;
      all.push_back(mk(w, 1));
      w = busy(); w.mdr_out = 1; w.ir_in = 1;
      all.push_back(mk(w, 0));
      plan_exec(iv, cf);
      foreach (steps[i]) all.push_back(steps[i]);
      foreach (all[s]) begin
         int n;
         n = all[s].mem ? ((s == 1) ? fdly : mdly) : 0;
         for (int j = 0; j <= n; j++) begin
            logic mr, st;
            mr = all[s].mem ? (j == n) : 1'($urandom);
            st = (idx == stop_at);
            w = all[s].cw;
            if (all[s].mem && !mr) w.pc_in = 1'b0;
            if (idx == abort_at) begin
               do_reset(w, mr);
               return;
            end
            seen = seen | st;
            do_cycle(w, 1'b0, mr, cf, st);
            idx++;
         end
         if (s == 2) ir = iv;
      end
      if (seen || iv[31:27] == OP_HALT) begin
         for (int k = 0; k < 4; k++) do_cycle(zero(), 1'b0, 1'($urandom), cf, 1'($urandom));
         do_reset(zero(), 1'b1);
      end
   endtask

   initial begin : monitor
      exp_t e;
      cw_t  a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_word();
            checks++;
            if (a !== e.cw) begin
               errors++;
               $display("FAIL %s @%0t: got %h, want %h, diff %h", e.tag, $time, a, e.cw,
                        a ^ e.cw);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: stimulus did not complete, got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      clr = 1'b1; mem_ready = 1'b0; con_ff = 1'b0; stop = 1'b0; ir = 32'd0;
      @(posedge clk);
      #1;
      do_reset(zero(), 1'b0);

      run_instr(mk_ir(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b0, 0, 0, -1, -1, "add_r3_r1_r2");
      run_instr(mk_ir(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b0, 0, 0, -1, 4, "clr_mid_t4");
      run_instr(mk_ir(OP_OR, 4'd5, 4'd6, 4'd7), 1'b1, 3, 0, -1, -1, "fetch_stall");
      run_instr(mk_ir(OP_BR, 4'd4, 4'd0, 4'd0), 1'b0, 0, 0, -1, -1, "br_not_taken");
      run_instr(mk_ir(OP_BR, 4'd4, 4'd0, 4'd0), 1'b1, 1, 0, -1, -1, "br_taken");
      run_instr(mk_ir(OP_ST, 4'd9, 4'd2, 4'd0), 1'b0, 0, 2, -1, -1, "st_late");
      run_instr(mk_ir(OP_LD, 4'd8, 4'd0, 4'd0), 1'b0, 0, 1, -1, -1, "ld_r0_base");
      run_instr(mk_ir(OP_LDI, 4'd15, 4'd3, 4'd0), 1'b0, 0, 0, -1, -1, "ldi");
      run_instr(mk_ir(OP_ADDI, 4'd1, 4'd2, 4'd0), 1'b0, 0, 0, -1, -1, "addi");
      run_instr(mk_ir(OP_JAL, 4'd6, 4'd0, 4'd0), 1'b0, 0, 0, -1, -1, "jal");
      run_instr(mk_ir(OP_NEG, 4'd12, 4'd13, 4'd0), 1'b0, 0, 0, -1, -1, "neg");
      run_instr(mk_ir(5'b11110, 4'd1, 4'd1, 4'd1), 1'b0, 0, 0, -1, -1, "undefined_op");
      run_instr(mk_ir(OP_MUL, 4'd2, 4'd3, 4'd0), 1'b0, 0, 0, 1, -1, "mul_stop_halt");
      run_instr(mk_ir(OP_HALT, 4'd0, 4'd0, 4'd0), 1'b0, 0, 0, -1, -1, "halt_op");
      run_instr(mk_ir(OP_JR, 4'd10, 4'd0, 4'd0), 1'b0, 2, 0, -1, 1, "clr_in_stall");

      for (int i = 0; i < 200; i++) begin
         logic [31:0] iv;
         int          sa, aa;
         iv = $urandom;
         sa = ($urandom_range(9, 0) == 0) ? int'($urandom_range(12, 0)) : -1;
         aa = ($urandom_range(14, 0) == 0) ? int'($urandom_range(10, 0)) : -1;
         run_instr(iv, 1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   sa, aa, $sformatf("rand%0d", i));
      end

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
